// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the configurable UART: parity modes, FSM encodings,
// oversample ratio and the parity function used by both TX and RX.
package uart_cfg_pkg;

    localparam int OVERSAMPLE  = 16;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_PARITY    = 3'd3;
    localparam logic [2:0] RX_STOP      = 3'd4;
    localparam logic [2:0] RX_WAIT_IDLE = 3'd5;

    // Payload is zero-extended to 9 bits, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle tick every CLOCK_DIVIDE clocks,
// realigned by restart so the first tick lands CLOCK_DIVIDE cycles later.
module uart_tick_gen #(
    parameter int CLOCK_DIVIDE = 325
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(CLOCK_DIVIDE);
    localparam logic [W-1:0] RELOAD = W'(CLOCK_DIVIDE - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || restart || (cnt_q == '0)) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0) && !restart;

endmodule

// File: rtl/uart_cfg.sv
// Full-duplex UART, 16x oversampling, elaboration-time frame format.
// TX and RX are independent; each owns its own tick generator.
module uart_cfg
    import uart_cfg_pkg::*;
#(
    parameter int CLOCK_DIVIDE = 325,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 rx_busy,
    output logic                 tx_busy
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SMP_A   = 4'd7;
    localparam logic [3:0] SMP_B   = 4'd8;
    localparam logic [3:0] SMP_C   = 4'd9;

    // ---------------- transmitter ----------------
    logic [2:0]           tx_state_q, tx_state_d;
    logic [3:0]           tx_os_q, tx_os_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_stop_q, tx_stop_d;
    logic                 tx_q, tx_d;
    logic                 tx_tick, tx_accept, tx_bit_end;

    assign tx_accept  = tx_valid && (tx_state_q == TX_IDLE);
    assign tx_bit_end = tx_tick && (tx_os_q == OS_LAST);

    uart_tick_gen #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_tx_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(tx_accept),
        .tick   (tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = tx_tick ? tx_os_q + 4'd1 : tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_stop_d  = tx_stop_q;
        tx_d       = tx_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_accept) begin
                    tx_state_d = TX_START;
                    tx_os_d    = '0;
                    tx_shift_d = tx_data;
                    tx_par_d   = parity_bit(9'(tx_data), PARITY);
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == LAST_BIT) begin
                        tx_stop_d = 1'b0;
                        if (PARITY != PARITY_NONE) begin
                            tx_state_d = TX_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_stop_q  <= tx_stop_d;
            tx_q       <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (tx_state_q == TX_IDLE);
    assign tx_busy  = !tx_ready;

    // ---------------- receiver ----------------
    logic                 rx_s1_q, rx_s2_q;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [3:0]           rx_os_q, rx_os_d;
    logic [3:0]           rx_ones_q, rx_ones_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 smp_a_q, smp_a_d, smp_b_q, smp_b_d;
    logic                 pe_pend_q, pe_pend_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 rx_tick, rx_start, decide, maj;

    assign rx_start = (rx_state_q == RX_IDLE) && !rx_s2_q;
    assign decide   = rx_tick && (rx_os_q == SMP_C);
    assign maj      = (smp_a_q & smp_b_q) | (smp_a_q & rx_s2_q) | (smp_b_q & rx_s2_q);

    uart_tick_gen #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_rx_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(rx_start),
        .tick   (rx_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_os_d    = rx_tick ? rx_os_q + 4'd1 : rx_os_q;
        rx_ones_d  = rx_ones_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        smp_a_d    = (rx_tick && rx_os_q == SMP_A) ? rx_s2_q : smp_a_q;
        smp_b_d    = (rx_tick && rx_os_q == SMP_B) ? rx_s2_q : smp_b_q;
        pe_pend_d  = pe_pend_q;
        rx_valid_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_start) begin
                    rx_state_d = RX_START;
                    rx_os_d    = '0;
                end
            end
            RX_START: begin
                if (decide) begin
                    rx_state_d = maj ? RX_IDLE : RX_DATA;
                    rx_bit_d   = '0;
                    pe_pend_d  = 1'b0;
                end
            end
            RX_DATA: begin
                if (decide) begin
                    rx_shift_d = {maj, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (decide) begin
                    pe_pend_d  = maj != parity_bit(9'(rx_shift_q), PARITY);
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // Returning to idle mid-stop leaves room to catch the next start edge.
                if (decide) begin
                    if (maj) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                        perr_d     = pe_pend_q;
                        rx_state_d = RX_IDLE;
                    end else begin
                        ferr_d     = 1'b1;
                        rx_ones_d  = '0;
                        rx_state_d = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_tick) begin
                    if (!rx_s2_q) begin
                        rx_ones_d = '0;
                    end else if (rx_ones_q == OS_LAST) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_ones_d = rx_ones_q + 4'd1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_os_q    <= '0;
            rx_ones_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            smp_a_q    <= 1'b1;
            smp_b_q    <= 1'b1;
            pe_pend_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_os_q    <= rx_os_d;
            rx_ones_q  <= rx_ones_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            smp_a_q    <= smp_a_d;
            smp_b_q    <= smp_b_d;
            pe_pend_q  <= pe_pend_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign rx_busy       = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: three instances (8N1, 8E2, 7O1) at CLOCK_DIVIDE=4,
// scoreboarded against a frame-level reference model.
module tb_uart_cfg;

    localparam int NU  = 3;
    localparam int BIT = 64;

    typedef struct packed {
        logic       v;
        logic       pe;
        logic       fe;
        logic [8:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid [NU];
    logic [8:0] tx_data  [NU];
    logic       tx_w     [NU];
    logic       rx_w     [NU];
    logic       tx_rdy   [NU];
    logic       tx_bsy   [NU];
    logic       rx_vld   [NU];
    logic       perr     [NU];
    logic       ferr     [NU];
    logic       rx_bsy   [NU];
    logic [8:0] rx_dat   [NU];
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       inj_en, inj_line;

    exp_t       sbq [NU][$];
    logic [8:0] last_good [NU];
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign rx_dat[0] = {1'b0, d0};
    assign rx_dat[1] = {1'b0, d1};
    assign rx_dat[2] = {2'b00, d2};
    assign rx_w[0]   = tx_w[0];
    assign rx_w[1]   = inj_en ? inj_line : tx_w[1];
    assign rx_w[2]   = tx_w[2];

    uart_cfg #(.CLOCK_DIVIDE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .rx(rx_w[0]), .tx(tx_w[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_rdy[0]), .tx_data(tx_data[0][7:0]),
        .rx_valid(rx_vld[0]), .rx_data(d0), .parity_error(perr[0]),
        .framing_error(ferr[0]), .rx_busy(rx_bsy[0]), .tx_busy(tx_bsy[0])
    );

    uart_cfg #(.CLOCK_DIVIDE(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .rx(rx_w[1]), .tx(tx_w[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_rdy[1]), .tx_data(tx_data[1][7:0]),
        .rx_valid(rx_vld[1]), .rx_data(d1), .parity_error(perr[1]),
        .framing_error(ferr[1]), .rx_busy(rx_bsy[1]), .tx_busy(tx_bsy[1])
    );

    uart_cfg #(.CLOCK_DIVIDE(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .rx(rx_w[2]), .tx(tx_w[2]),
        .tx_valid(tx_valid[2]), .tx_ready(tx_rdy[2]), .tx_data(tx_data[2][6:0]),
        .rx_valid(rx_vld[2]), .rx_data(d2), .parity_error(perr[2]),
        .framing_error(ferr[2]), .rx_busy(rx_bsy[2]), .tx_busy(tx_bsy[2])
    );

    // Frame format of each instance, as plain numbers.
    function automatic int dbits(input int u);
        return (u == 2) ? 7 : 8;
    endfunction

    function automatic int pmode(input int u);
        return u;
    endfunction

    function automatic int sbits(input int u);
        return (u == 1) ? 2 : 1;
    endfunction

    function automatic logic [8:0] mask(input int u);
        return (u == 2) ? 9'h07F : 9'h0FF;
    endfunction

    function automatic logic par_of(input int u, input logic [8:0] d);
        int ones;
        ones = $countones(d & mask(u));
        return (pmode(u) == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
    endfunction

    task automatic build_frame(input int u, input logic [8:0] d,
                               output logic fr [16], output int n);
        for (int i = 0; i < 16; i++) fr[i] = 1'b1;
        fr[0] = 1'b0;
        n = 1;
        for (int i = 0; i < dbits(u); i++) begin
            fr[n] = d[i];
            n++;
        end
        if (pmode(u) != 0) begin
            fr[n] = par_of(u, d);
            n++;
        end
        n = n + sbits(u);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_rx(input int u, input exp_t e);
        sbq[u].push_back(e);
        if (e.v) last_good[u] = e.d;
    endtask

    for (genvar g = 0; g < NU; g++) begin : g_mon
        always @(negedge clk) begin
            exp_t e;
            if (!rst && (rx_vld[g] || perr[g] || ferr[g])) begin
                if (sbq[g].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL u%0d_unexpected: v=%b pe=%b fe=%b d=%0h expected none",
                             g, rx_vld[g], perr[g], ferr[g], rx_dat[g]);
                end else begin
                    e = sbq[g].pop_front();
                    check($sformatf("u%0d_rx_valid", g), 32'(rx_vld[g]), 32'(e.v));
                    check($sformatf("u%0d_rx_data", g), 32'(rx_dat[g]), 32'(e.d));
                    check($sformatf("u%0d_parity_err", g), 32'(perr[g]), 32'(e.pe));
                    check($sformatf("u%0d_framing_err", g), 32'(ferr[g]), 32'(e.fe));
                end
            end
        end
    end

    // Waits for tx_ready, hands over one word, and predicts the looped-back frame.
    task automatic send(input int u, input logic [8:0] d);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!tx_rdy[u] && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!tx_rdy[u]) begin
            n_chk++;
            n_fail++;
            $display("FAIL u%0d_send_timeout: tx_ready=%b expected 1", u, tx_rdy[u]);
        end else begin
            tx_valid[u] = 1'b1;
            tx_data[u]  = d;
            if (u != 1 || !inj_en) begin
                e = '{v: 1'b1, pe: 1'b0, fe: 1'b0, d: d & mask(u)};
                expect_rx(u, e);
            end
            @(negedge clk);
            tx_valid[u] = 1'b0;
            tx_data[u]  = 9'($urandom);
        end
    endtask

    // Drives an 8E1 frame on u1's RX line; optional 4-clk high glitch in one bit.
    task automatic inject(input logic [8:0] d, input logic flip,
                          input logic stop_v, input int glitch_bit);
        logic fr [16];
        int   n;
        build_frame(1, d, fr, n);
        fr[9]  = fr[9] ^ flip;
        fr[10] = stop_v;
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < BIT; c++) begin
                inj_line = (i == glitch_bit && c >= 32 && c < 36) ? 1'b1 : fr[i];
                @(negedge clk);
            end
        end
        inj_line = 1'b1;
    endtask

    task automatic drain(input int limit);
        int w;
        w = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && w < limit) begin
            @(negedge clk);
            w++;
        end
        repeat (BIT) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic fr [16];
        int   n, k;
        int   bad [16];
        exp_t e;

        inj_en   = 1'b0;
        inj_line = 1'b1;
        for (int u = 0; u < NU; u++) begin
            tx_valid[u]  = 1'b0;
            tx_data[u]   = '0;
            last_good[u] = '0;
        end
        repeat (5) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            check($sformatf("u%0d_rst_tx", u), 32'(tx_w[u]), 32'd1);
            check($sformatf("u%0d_rst_tx_ready", u), 32'(tx_rdy[u]), 32'd1);
            check($sformatf("u%0d_rst_tx_busy", u), 32'(tx_bsy[u]), 32'd0);
            check($sformatf("u%0d_rst_rx_valid", u), 32'(rx_vld[u]), 32'd0);
            check($sformatf("u%0d_rst_rx_data", u), 32'(rx_dat[u]), 32'd0);
            check($sformatf("u%0d_rst_perr", u), 32'(perr[u]), 32'd0);
            check($sformatf("u%0d_rst_ferr", u), 32'(ferr[u]), 32'd0);
            check($sformatf("u%0d_rst_rx_busy", u), 32'(rx_bsy[u]), 32'd0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 waveform of 0xA5, cycle by cycle.
        build_frame(0, 9'h0A5, fr, n);
        for (int i = 0; i < 16; i++) bad[i] = 0;
        send(0, 9'h0A5);
        for (k = 1; k <= n * BIT; k++) begin
            if (k > 1) @(negedge clk);
            if (tx_w[0] !== fr[(k - 1) / BIT]) bad[(k - 1) / BIT]++;
        end
        for (int i = 0; i < n; i++)
            check($sformatf("u0_a5_bit%0d_badcycles", i), 32'(bad[i]), 32'd0);
        check("u0_a5_ready_last_stop", 32'(tx_rdy[0]), 32'd0);
        @(negedge clk);
        check("u0_a5_ready_after", 32'(tx_rdy[0]), 32'd1);

        // Fixed patterns on 8E2 and 7O1 loopbacks, plus 8E2 frame length.
        fork
            begin
                send(1, 9'h000);
                k = 1;
                while (!tx_rdy[1] && k < 2000) begin
                    @(negedge clk);
                    k++;
                end
                check("u1_8e2_frame_len", 32'(k - 1), 32'(12 * BIT));
                send(1, 9'h0FF);
                send(1, 9'h055);
                send(1, 9'h07F);
            end
            begin
                send(2, 9'h000);
                send(2, 9'h0FF);
                send(2, 9'h055);
                send(2, 9'h07F);
            end
        join
        drain(3000);

        // Random traffic on all three, with ignored tx_valid while busy on u0.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(0, 9'($urandom));
                    tx_valid[0] = 1'b1;
                    tx_data[0]  = 9'($urandom);
                    repeat (10) @(negedge clk);
                    tx_valid[0] = 1'b0;
                    repeat ($urandom_range(0, 80)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    send(1, 9'($urandom));
                    repeat ($urandom_range(0, 80)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    send(2, 9'($urandom));
                    repeat ($urandom_range(0, 80)) @(negedge clk);
                end
            end
        join
        drain(5000);

        // Injected frames on u1.
        inj_en = 1'b1;
        repeat (20) @(negedge clk);
        e = '{v: 1'b1, pe: 1'b1, fe: 1'b0, d: 9'h03C};
        expect_rx(1, e);
        inject(9'h03C, 1'b1, 1'b1, -1);
        repeat (2 * BIT) @(negedge clk);

        e = '{v: 1'b0, pe: 1'b0, fe: 1'b1, d: last_good[1]};
        expect_rx(1, e);
        inject(9'h081, 1'b0, 1'b0, -1);
        inj_line = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check("u1_break_busy", 32'(rx_bsy[1]), 32'd1);
        inj_line = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("u1_break_released", 32'(rx_bsy[1]), 32'd0);
        e = '{v: 1'b1, pe: 1'b0, fe: 1'b0, d: 9'h042};
        expect_rx(1, e);
        inject(9'h042, 1'b0, 1'b1, -1);
        repeat (2 * BIT) @(negedge clk);

        inj_line = 1'b0;
        repeat (20) @(negedge clk);
        inj_line = 1'b1;
        repeat (100) @(negedge clk);
        check("u1_start_glitch_idle", 32'(rx_bsy[1]), 32'd0);
        e = '{v: 1'b1, pe: 1'b0, fe: 1'b0, d: 9'h000};
        expect_rx(1, e);
        inject(9'h000, 1'b0, 1'b1, 4);
        repeat (2 * BIT) @(negedge clk);
        drain(2000);
        inj_en = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in the middle of a u1 loopback frame.
        send(1, 9'h096);
        repeat (279) @(negedge clk);
        check("u1_pre_rst_tx_busy", 32'(tx_bsy[1]), 32'd1);
        check("u1_pre_rst_rx_busy", 32'(rx_bsy[1]), 32'd1);
        rst = 1'b1;
        sbq[1].delete();
        @(negedge clk);
        check("u1_post_rst_tx", 32'(tx_w[1]), 32'd1);
        check("u1_post_rst_tx_ready", 32'(tx_rdy[1]), 32'd1);
        check("u1_post_rst_rx_busy", 32'(rx_bsy[1]), 32'd0);
        check("u1_post_rst_rx_valid", 32'(rx_vld[1]), 32'd0);
        check("u1_post_rst_rx_data", 32'(rx_dat[1]), 32'd0);
        check("u1_post_rst_errs", 32'({perr[1], ferr[1]}), 32'd0);
        rst = 1'b0;
        last_good[1] = '0;
        repeat (16 * BIT) @(negedge clk);
        send(1, 9'h05A);
        drain(3000);

        for (int u = 0; u < NU; u++)
            check($sformatf("u%0d_scoreboard_empty", u), 32'(sbq[u].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
